// File: rtl/census_hamming_wta.sv
// rtl/census_hamming_wta.sv - census Hamming cost pipeline with winner-take-all disparity tracking
// Optional second-best cost tracking and op 6 READ_SECOND: define CENSUS_WTA_SECOND_BEST_EN.
module census_hamming_wta #(
    parameter int MAX_DISP = 64,
    parameter int CODE_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r
);
    localparam logic [3:0] OP_LOAD_REF   = 4'd1;
    localparam logic [3:0] OP_MATCH      = 4'd2;
    localparam logic [3:0] OP_READ_BEST  = 4'd3;
    localparam logic [3:0] OP_READ_LAST  = 4'd4;
    localparam logic [3:0] OP_CLEAR      = 4'd5;
`ifdef CENSUS_WTA_SECOND_BEST_EN
    localparam logic [3:0] OP_READ_SECOND = 4'd6;
`endif
    localparam logic [8:0] LP_MAX_DISP = 9'(MAX_DISP);
    localparam logic [5:0] LP_NO_COST  = 6'h3F;

    function automatic logic [5:0] popcnt(input logic [CODE_W-1:0] x);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < CODE_W; i++) begin
            cnt += {5'd0, x[i]};
        end
        return cnt;
    endfunction

    logic [CODE_W-1:0] r_ref;
    logic [CODE_W-1:0] r_s1_xa;
    logic [CODE_W-1:0] r_s1_xb;
    logic [7:0]        r_s1_disp;
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [5:0]        r_best_cost;
    logic [7:0]        r_best_disp;
    logic [7:0]        r_disp_cnt;
    logic              r_ovf;
    logic [5:0]        r_last_a;
    logic [5:0]        r_last_b;

    logic [5:0]        w_cost_a;
    logic [5:0]        w_cost_b;
    logic              w_a_wins;
    logic              w_b_wins;
    logic [5:0]        w_best_mid;
    logic [5:0]        w_best_next;
    logic [7:0]        w_disp_next;
    logic              w_room;
    logic              w_empty;

    // A is compared first so ties always resolve toward the lower disparity.
    assign w_cost_a    = popcnt(r_s1_xa);
    assign w_cost_b    = popcnt(r_s1_xb);
    assign w_a_wins    = w_cost_a < r_best_cost;
    assign w_best_mid  = w_a_wins ? w_cost_a : r_best_cost;
    assign w_b_wins    = w_cost_b < w_best_mid;
    assign w_best_next = w_b_wins ? w_cost_b : w_best_mid;
    assign w_disp_next = w_b_wins ? (r_s1_disp + 8'd1) : (w_a_wins ? r_s1_disp : r_best_disp);
    assign w_room      = ({1'b0, r_disp_cnt} + 9'd2) <= LP_MAX_DISP;
    assign w_empty     = !r_s1_valid && !r_s2_valid;

`ifdef CENSUS_WTA_SECOND_BEST_EN
    logic [5:0] r_second_cost;
    logic [5:0] w_second_mid;
    logic [5:0] w_second_next;

    // A displaced best becomes second; a losing candidate may still beat second.
    assign w_second_mid  = w_a_wins ? r_best_cost :
                           ((w_cost_a < r_second_cost) ? w_cost_a : r_second_cost);
    assign w_second_next = w_b_wins ? w_best_mid :
                           ((w_cost_b < w_second_mid) ? w_cost_b : w_second_mid);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r           <= 32'd0;
            r_ref       <= '0;
            r_s1_xa     <= '0;
            r_s1_xb     <= '0;
            r_s1_disp   <= 8'd0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_best_cost <= LP_NO_COST;
            r_best_disp <= 8'd0;
            r_disp_cnt  <= 8'd0;
            r_ovf       <= 1'b0;
            r_last_a    <= 6'd0;
            r_last_b    <= 6'd0;
`ifdef CENSUS_WTA_SECOND_BEST_EN
            r_second_cost <= LP_NO_COST;
`endif
        end else if (clk_en) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_best_cost <= w_best_next;
                r_best_disp <= w_disp_next;
                r_last_a    <= w_cost_a;
                r_last_b    <= w_cost_b;
`ifdef CENSUS_WTA_SECOND_BEST_EN
                r_second_cost <= w_second_next;
`endif
            end

            // Op effects are written after the retire so a flush overrides it.
            case (op)
                OP_LOAD_REF: begin
                    r           <= 32'd0;
                    r_ref       <= a[CODE_W-1:0];
                    r_s1_valid  <= 1'b0;
                    r_s2_valid  <= 1'b0;
                    r_best_cost <= LP_NO_COST;
                    r_best_disp <= 8'd0;
                    r_disp_cnt  <= 8'd0;
                    r_ovf       <= 1'b0;
                    r_last_a    <= 6'd0;
                    r_last_b    <= 6'd0;
`ifdef CENSUS_WTA_SECOND_BEST_EN
                    r_second_cost <= LP_NO_COST;
`endif
                end
                OP_MATCH: begin
                    if (w_room) begin
                        r_s1_xa    <= a[CODE_W-1:0] ^ r_ref;
                        r_s1_xb    <= b[CODE_W-1:0] ^ r_ref;
                        r_s1_disp  <= r_disp_cnt;
                        r_s1_valid <= 1'b1;
                        r_disp_cnt <= r_disp_cnt + 8'd2;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                OP_READ_BEST: begin
                    r <= {w_empty, r_ovf, 6'b0, r_disp_cnt, r_best_disp, 2'b0, r_best_cost};
                end
                OP_READ_LAST: begin
                    r <= {10'b0, r_last_b, 10'b0, r_last_a};
                end
                OP_CLEAR: begin
                    r           <= 32'd0;
                    r_ref       <= '0;
                    r_s1_valid  <= 1'b0;
                    r_s2_valid  <= 1'b0;
                    r_best_cost <= LP_NO_COST;
                    r_best_disp <= 8'd0;
                    r_disp_cnt  <= 8'd0;
                    r_ovf       <= 1'b0;
                    r_last_a    <= 6'd0;
                    r_last_b    <= 6'd0;
`ifdef CENSUS_WTA_SECOND_BEST_EN
                    r_second_cost <= LP_NO_COST;
`endif
                end
`ifdef CENSUS_WTA_SECOND_BEST_EN
                OP_READ_SECOND: begin
                    r <= {26'b0, r_second_cost};
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_census_hamming_wta.sv
// tb/tb_census_hamming_wta.sv - randomized bench for census_hamming_wta against a candidate-list model
module tb_census_hamming_wta;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r64;
    logic [31:0] r4;

    census_hamming_wta #(.MAX_DISP(64), .CODE_W(32)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .op(op), .a(a), .b(b), .r(r64)
    );
    census_hamming_wta #(.MAX_DISP(4), .CODE_W(32)) dut4 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .op(op), .a(a), .b(b), .r(r4)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          cmp_en = 1'b0;
    int          e_cnt = 10;
    int          max_d[2] = '{64, 4};
    int          cand_cost[2][256];
    int          cand_edge[2][256];
    int          n_cand[2];
    bit          ovf_m[2];
    logic [31:0] ref_m[2];
    logic [31:0] exp_r[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            n_cand[m] = 0;
            ovf_m[m]  = 1'b0;
            ref_m[m]  = 32'd0;
            exp_r[m]  = 32'd0;
        end
    endtask

    // Candidates issued at enabled edge N are visible to ops at edge N+2 onward;
    // the pipeline reads as busy for ops at edges N+1 and N+2.
    task automatic model_edge(input int m, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
        int best = 63;
        int bidx = -1;
        int second = 63;
        int lastk = -1;
        int la = 0;
        int lb = 0;
        bit busy = 1'b0;
        logic [7:0] bd;
        for (int k = 0; k < n_cand[m]; k++) begin
            if (cand_edge[m][k] + 2 <= e_cnt) begin
                if (cand_cost[m][k] < best) begin
                    best = cand_cost[m][k];
                    bidx = k;
                end
                if (k % 2 == 0) lastk = k;
            end
            if (cand_edge[m][k] + 2 >= e_cnt) busy = 1'b1;
        end
        for (int k = 0; k < n_cand[m]; k++) begin
            if (cand_edge[m][k] + 2 <= e_cnt && k != bidx && cand_cost[m][k] < second)
                second = cand_cost[m][k];
        end
        if (lastk >= 0) begin
            la = cand_cost[m][lastk];
            lb = cand_cost[m][lastk + 1];
        end
        bd = (bidx < 0) ? 8'd0 : 8'(bidx);
        case (o)
            4'd1: begin
                exp_r[m]  = 32'd0;
                ref_m[m]  = va;
                n_cand[m] = 0;
                ovf_m[m]  = 1'b0;
            end
            4'd2: begin
                if (n_cand[m] + 2 <= max_d[m]) begin
                    cand_cost[m][n_cand[m]]     = $countones(va ^ ref_m[m]);
                    cand_cost[m][n_cand[m] + 1] = $countones(vb ^ ref_m[m]);
                    cand_edge[m][n_cand[m]]     = e_cnt;
                    cand_edge[m][n_cand[m] + 1] = e_cnt;
                    n_cand[m] += 2;
                end else begin
                    ovf_m[m] = 1'b1;
                end
            end
            4'd3: exp_r[m] = {~busy, ovf_m[m], 6'b0, 8'(n_cand[m]), bd, 2'b0, 6'(best)};
            4'd4: exp_r[m] = {10'b0, 6'(lb), 10'b0, 6'(la)};
            4'd5: begin
                exp_r[m]  = 32'd0;
                ref_m[m]  = 32'd0;
                n_cand[m] = 0;
                ovf_m[m]  = 1'b0;
            end
`ifdef CENSUS_WTA_SECOND_BEST_EN
            4'd6: exp_r[m] = {26'b0, 6'(second)};
`endif
            default: begin
            end
        endcase
    endtask

    task automatic step(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb, input logic en);
        op = o;
        a = va;
        b = vb;
        clk_en = en;
        @(posedge clk);
        if (en) begin
            model_edge(0, o, va, vb);
            model_edge(1, o, va, vb);
            e_cnt++;
        end
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] want64, input logic [31:0] want4);
        check({name, "_md64"}, r64, want64);
        check({name, "_md4"}, r4, want4);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("r_md64", r64, exp_r[0]);
            check("r_md4", r4, exp_r[1]);
        end
    end

    initial begin
        logic [3:0]  o;
        logic [31:0] va;
        logic [31:0] vb;
        logic        en;
        int          pick;
        reset = 1'b0;
        clk_en = 1'b0;
        op = 4'd0;
        a = 32'd0;
        b = 32'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        lit("reset_r", 32'd0, 32'd0);
        reset = 1'b1;
        cmp_en = 1'b1;

        step(4'd3, 0, 0, 1'b1);
        lit("rst_best", 32'h8000003F, 32'h8000003F);

        step(4'd1, 32'h00808080, 0, 1'b1);
        step(4'd2, 32'hA1234567, 32'h00808080, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("first_best", 32'h80020100, 32'h80020100);
        step(4'd4, 0, 0, 1'b1);
        lit("first_last", 32'h00000011, 32'h00000011);

        step(4'd1, 0, 0, 1'b1);
        step(4'd2, 32'h0000000F, 32'h000000F0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("tie_best", 32'h80020004, 32'h80020004);
        step(4'd2, 32'hFFFFFFFF, 32'h00000007, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("second_pair", 32'h80040303, 32'h80040303);
        step(4'd2, 32'h0, 32'h0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("ovf", 32'h80060400, 32'hC0040303);

        step(4'd2, 32'h12345678, 32'h0, 1'b1);
        step(4'd1, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("flush_best", 32'h8000003F, 32'h8000003F);
        step(4'd4, 0, 0, 1'b1);
        lit("flush_last", 32'h0, 32'h0);

        step(4'd1, 32'h00808080, 0, 1'b1);
        step(4'd2, 32'hA1234567, 32'h00808080, 1'b1);
        repeat (6) step(4'd3, 0, 0, 1'b0);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("clk_en_hold", 32'h80020100, 32'h80020100);

        step(4'd1, 0, 0, 1'b1);
        step(4'd2, 32'h1, 32'h3, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        lit("sb_best", 32'h80020001, 32'h80020001);
        step(4'd6, 0, 0, 1'b1);
`ifdef CENSUS_WTA_SECOND_BEST_EN
        lit("sb_second", 32'h00000002, 32'h00000002);
`else
        lit("op6_nop", 32'h80020001, 32'h80020001);
`endif

        step(4'd1, 0, 0, 1'b1);
        step(4'd2, 32'h5, 32'h6, 1'b1);
        do_reset();
        step(4'd3, 0, 0, 1'b1);
        lit("mid_reset", 32'h8000003F, 32'h8000003F);

        for (int i = 0; i < 800; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 50)      o = 4'd2;
            else if (pick < 62) o = 4'd3;
            else if (pick < 72) o = 4'd4;
            else if (pick < 76) o = 4'd1;
            else if (pick < 78) o = 4'd5;
            else if (pick < 84) o = 4'd6;
            else if (pick < 90) o = 4'd0;
            else                o = 4'($urandom_range(7, 15));
            en = ($urandom_range(0, 99) < 85);
            va = $urandom_range(0, 1) ? (ref_m[0] ^ 32'($urandom_range(0, 255))) : $urandom;
            vb = $urandom_range(0, 1) ? (ref_m[0] ^ 32'($urandom_range(0, 255))) : $urandom;
            step(o, va, vb, en);
            if (i == 400) do_reset();
        end
        step(4'd0, 0, 0, 1'b1);
        step(4'd3, 0, 0, 1'b1);
        step(4'd0, 0, 0, 1'b1);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
